// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        SEQ  = 2'd2,
        RUN  = 2'd3
    } seqState_t;

    // Down-counter width: wide enough for the larger load value, never zero bits.
    function automatic int cntWidth(input int step, input int hold);
        int max_v;
        int w;
        max_v = (step > hold) ? step : hold;
        w     = $clog2(max_v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Reset-deassert synchroniser: async-clear flop chain shifting in a constant one.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic released_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; clears immediately on reset, fills with ones after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign released_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release sequencer: synchronised power-up release of CHANNELS
// resets one at a time, with cascading per-channel software resets.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STEP_CYCLES = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] swRst_i,
    output logic [CHANNELS-1:0] rst_o,
    output logic                ready_o
);

    localparam int CW = cntWidth(STEP_CYCLES, HOLD_CYCLES);
    localparam int PW = $clog2(CHANNELS) + 1;
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] LAST_CH   = PW'(CHANNELS - 1);

    seqState_t           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;

    logic                released_s;
    logic [PW-1:0]       req_idx_s;
    logic [CHANNELS-1:0] req_mask_s;
    logic [CHANNELS-1:0] rel_mask_s;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_i),
        .released_o (released_s)
    );

    // Lowest-set-bit encoder; scanning downward lets the lowest index win.
    always_comb begin
        req_idx_s = {PW{1'b0}};
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            req_idx_s = swRst_i[i] ? PW'(i) : req_idx_s;
        end
    end

    // Cascade mask (requested channel and above) and single-channel release mask.
    always_comb begin
        req_mask_s = {CHANNELS{1'b0}};
        rel_mask_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            req_mask_s[i] = (PW'(i) >= req_idx_s);
            rel_mask_s[i] = (PW'(i) == ptr_q);
        end
    end

    // Sequencer state, counter, pointer and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= SYNC;
            cnt_q   <= {CW{1'b0}};
            ptr_q   <= {PW{1'b0}};
            rst_q   <= {CHANNELS{1'b1}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic; a pending request outranks any release in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        if ((state_q != SYNC) && (|swRst_i)) begin
            rst_d   = rst_q | req_mask_s;
            ptr_d   = (req_idx_s < ptr_q) ? req_idx_s : ptr_q;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (released_s) begin
                        cnt_d   = STEP_LOAD;
                        state_d = SEQ;
                    end else begin
                        state_d = SYNC;
                    end
                end
                HOLD: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        cnt_d   = STEP_LOAD;
                        state_d = SEQ;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SEQ: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        rst_d = rst_q & ~rel_mask_s;
                        ptr_d = ptr_q + PW'(1);
                        if (ptr_q == LAST_CH) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            cnt_d = STEP_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RUN: begin
                    rst_d   = {CHANNELS{1'b0}};
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    assign rst_o   = rst_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench: default 4-channel instance plus a 1-channel,
// 1-cycle-step instance for the parameter corner.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] rst_o;
    logic       ready;
    logic       rst1_n;
    logic       sw1;
    logic       rst1_o;
    logic       ready1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS(4), .SYNC_STAGES(2), .STEP_CYCLES(16), .HOLD_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .swRst_i(sw), .rst_o(rst_o), .ready_o(ready)
    );

    reset_sequencer #(
        .CHANNELS(1), .SYNC_STAGES(2), .STEP_CYCLES(1), .HOLD_CYCLES(8)
    ) dut1 (
        .clk_i(clk), .rst_i(rst1_n), .swRst_i(sw1), .rst_o(rst1_o), .ready_o(ready1)
    );

    task automatic test_reset();
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        sw     = 4'b0000;
        sw1    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, rst_o} !== 5'b01111)
            $display("FAIL reset_main: got ready/rst=%b want %b", {ready, rst_o}, 5'b01111);
        else passed++;
        checks++;
        if ({ready1, rst1_o} !== 2'b01)
            $display("FAIL reset_edge: got ready/rst=%b want %b", {ready1, rst1_o}, 2'b01);
        else passed++;
    endtask

    // Called #1 after a rising edge with rst_n low; the next edge is edge 1.
    task automatic test_powerup();
        int         rel[4];
        logic [4:0] exp;
        rel = '{19, 35, 51, 67};
        rst_n = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) exp[i] = (e < rel[i]);
            exp[4] = (e >= 67);
            checks++;
            if ({ready, rst_o} !== exp)
                $display("FAIL powerup edge %0d: got ready/rst=%b want %b", e, {ready, rst_o}, exp);
            else passed++;
        end
    endtask

    task automatic test_sw_run();
        logic [4:0] exp;
        sw = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ready, rst_o} !== 5'b01100)
                $display("FAIL sw_assert cycle %0d: got %b want %b", j, {ready, rst_o}, 5'b01100);
            else passed++;
        end
        sw = 4'b0000;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            #1;
            exp = {(j >= 40), (j < 40), (j < 24), 2'b00};
            checks++;
            if ({ready, rst_o} !== exp)
                $display("FAIL sw_release +%0d: got %b want %b", j, {ready, rst_o}, exp);
            else passed++;
        end
    endtask

    task automatic test_lower_in_seq();
        logic [4:0] exp;
        sw = 4'b1000;
        @(posedge clk);
        #1;
        sw = 4'b0000;
        checks++;
        if ({ready, rst_o} !== 5'b01000)
            $display("FAIL ch3_req: got %b want %b", {ready, rst_o}, 5'b01000);
        else passed++;
        // SEQ is entered 8 edges after the request's last sampled edge.
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ready, rst_o} !== 5'b01000)
                $display("FAIL ch3_wait +%0d: got %b want %b", j, {ready, rst_o}, 5'b01000);
            else passed++;
        end
        sw = 4'b0010;
        @(posedge clk);
        #1;
        sw = 4'b0000;
        checks++;
        if ({ready, rst_o} !== 5'b01110)
            $display("FAIL lower_req: got %b want %b", {ready, rst_o}, 5'b01110);
        else passed++;
        for (int j = 1; j <= 56; j++) begin
            @(posedge clk);
            #1;
            exp = {(j >= 56), (j < 56), (j < 40), (j < 24), 1'b0};
            checks++;
            if ({ready, rst_o} !== exp)
                $display("FAIL lower_release +%0d: got %b want %b", j, {ready, rst_o}, exp);
            else passed++;
        end
    endtask

    task automatic test_async_mid_hold();
        sw = 4'b0100;
        @(posedge clk);
        #1;
        sw = 4'b0000;
        checks++;
        if ({ready, rst_o} !== 5'b01100)
            $display("FAIL hold_entry: got %b want %b", {ready, rst_o}, 5'b01100);
        else passed++;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, rst_o} !== 5'b01111)
            $display("FAIL async_reset: got %b want %b", {ready, rst_o}, 5'b01111);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, rst_o} !== 5'b01111)
            $display("FAIL async_reset_held: got %b want %b", {ready, rst_o}, 5'b01111);
        else passed++;
        test_powerup();
    endtask

    task automatic test_edge_params();
        logic [1:0] exp;
        rst1_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 4), (e < 4)};
            checks++;
            if ({ready1, rst1_o} !== exp)
                $display("FAIL edge_powerup edge %0d: got %b want %b", e, {ready1, rst1_o}, exp);
            else passed++;
        end
        sw1 = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ready1, rst1_o} !== 2'b01)
                $display("FAIL edge_held cycle %0d: got %b want %b", j, {ready1, rst1_o}, 2'b01);
            else passed++;
        end
        sw1 = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            #1;
            exp = {(j >= 9), (j < 9)};
            checks++;
            if ({ready1, rst1_o} !== exp)
                $display("FAIL edge_release +%0d: got %b want %b", j, {ready1, rst1_o}, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_sw_run();
        test_lower_in_seq();
        test_async_mid_hold();
        test_edge_params();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
